port_commit_rob: RTL and testbench
==================================

Name: port_commit_rob

Overview:
- In-order reorder buffer for interconnect port connections. Sits directly downstream of the port allocation unit.
- Records every connection request issued by the Rename Unit and collects per-unit commit pulses.
- Retires connections in issue order. Each retirement produces:
  - a one-hot Ack, indexed by physical source ID, which releases the map-table row and commit-table row in the port allocation unit;
  - a release record that frees the rename entry.

Parameters:
- NUM_UNITS, 16, number of physical units (BRAMs plus IFLogics); also the width of the commit and ack vectors.
- WIDTH_PID, $clog2(NUM_UNITS), physical ID width.
- WIDTH_TAG, 4, rename-entry tag width, returned on release.
- DEPTH, 8, ROB entries; must be a power of two, at least 2.
- WIDTH_DEPTH, $clog2(DEPTH), pointer width.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- I_Req  in  1  allocate an entry (same cycle the port allocation unit receives its request)
- I_PSrcID  in  WIDTH_PID  physical source ID
- I_PDstID  in  WIDTH_PID  physical destination ID
- I_Tag  in  WIDTH_TAG  rename-entry tag
- O_Ready  out  1  entry available; equals ~O_Full
- I_Commit  in  NUM_UNITS  per-unit commit pulses, indexed by destination unit
- O_Ack  out  NUM_UNITS  one-hot retire ack, indexed by source unit; registered
- O_Release  out  1  rename-entry release valid; registered
- O_RelTag  out  WIDTH_TAG  tag of the retired entry
- O_RelPSrcID  out  WIDTH_PID  source ID of the retired entry
- O_RelPDstID  out  WIDTH_PID  destination ID of the retired entry
- O_Count  out  WIDTH_DEPTH+1  occupied entries
- O_Empty  out  1  Count==0
- O_Full  out  1  Count==DEPTH
- O_ErrOvf  out  1  sticky: I_Req while full
- O_ErrOrphan  out  1  sticky: commit bit matched no pending entry

Behaviour:
- Reset (synchronous, active-high) clears:
  - all entry Valid and Done bits, head and tail pointers, Count;
  - O_Ack, O_Release, O_RelTag, O_RelPSrcID, O_RelPDstID, both error flags.
- After reset: O_Empty=1, O_Full=0, O_Ready=1.
- Reset mid-operation discards all entries; no Ack or Release is issued for them.
- Entry fields: Valid, Done, PSrcID, PDstID, Tag. Storage is a circular buffer with head (oldest) and tail (next free).
- Allocate, when I_Req & ~O_Full:
  - write the entry at tail with Valid=1, Done=0;
  - tail increments modulo DEPTH (wraps from DEPTH-1 to 0).
- I_Req & O_Full: request dropped, O_ErrOvf<=1. Full is evaluated on registered Count, so a retire in the same cycle does not make room.
- Commit match, for each bit u set in I_Commit:
  - mark Done on the oldest entry, searching from head in circular order, that has Valid & ~Done & PDstID==u;
  - distinct bits set in the same cycle are handled independently;
  - if no such entry exists, O_ErrOrphan<=1;
  - an entry being allocated this cycle is not eligible for matching.
- Retire, at most one per cycle:
  - condition: head entry Valid & Done at a clock edge (Done set at edge t makes the entry retirable at edge t+1);
  - on retire: clear Valid and Done, head increments modulo DEPTH;
  - next cycle: O_Ack = one-hot(PSrcID), O_Release=1, Rel fields = entry fields, all for exactly one cycle;
  - otherwise O_Ack='0 and O_Release=0; Rel fields hold their last value.
- Latency: commit pulse at edge t on the head entry gives O_Ack/O_Release high during the cycle after edge t+1.
- Younger entries that are Done wait behind an un-Done head, so order is strict.
- Count update: +1 on allocate, -1 on retire, unchanged when both happen in the same cycle. Allocating when full is impossible; retiring when empty is impossible.
- O_Empty, O_Full and O_Ready are combinational from registered Count.

Decomposition:
- Additions to pkg_bram_if:
  - rob_entry_t struct {Valid, Done, PSrcID, PDstID, Tag};
  - ROB_DEPTH and WIDTH_ROB_DEPTH constants.
- Sub-module rob_oldest_match: combinational circular priority select.
  - Inputs: candidate vector, head pointer.
  - Outputs: found flag and index.
  - Instantiated once per unit, NUM_UNITS instances.

Test Plan:
1. Reset, then idle → O_Empty=1, O_Ready=1, O_Ack=0, O_Count=0.
2. Req(Src=2, Dst=5, Tag=3); after 2 cycles I_Commit[5] pulse → two cycles later O_Ack=16'h0004, O_Release=1, RelTag=3, for one cycle; then O_Empty=1.
3. Req A(1→4), then Req B(3→6); commit[6] first, commit[4] 3 cycles later → Ack for A (bit 1) in the cycle after edge t+1, then Ack for B (bit 3) the following cycle; no Ack before A's commit.
4. Fill with 8 requests → O_Full=1, O_Count=8; a 9th I_Req → dropped, O_ErrOvf=1, Count stays 8.
5. Two entries, both Dst=7, and one commit[7] → only the older entry is Done; a second commit[7] then retires the younger one.
6. I_Commit[9] with no pending Dst=9 → O_ErrOrphan=1. Retire and allocate 20 entries to cover pointer wrap → Acks arrive in issue order and Count is consistent throughout.

Source files
------------

// File: rtl/port_commit_rob_pkg.sv
// Shared constants and entry type for the port-connection reorder buffer.
// Unit IDs and rename tags are sized here so that the interface, the top and the sub-module all agree.
package port_commit_rob_pkg;

    localparam int NUM_UNITS       = 16;
    localparam int WIDTH_PID       = $clog2(NUM_UNITS);
    localparam int WIDTH_TAG       = 4;
    localparam int ROB_DEPTH       = 8;
    localparam int WIDTH_ROB_DEPTH = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [WIDTH_PID-1:0] psrc_id;
        logic [WIDTH_PID-1:0] pdst_id;
        logic [WIDTH_TAG-1:0] tag;
    } rob_entry_t;

    function automatic logic [NUM_UNITS-1:0] pid_onehot(input logic [WIDTH_PID-1:0] pid);
        pid_onehot      = '0;
        pid_onehot[pid] = 1'b1;
    endfunction

endpackage

// File: rtl/port_commit_rob_if.sv
// Rename-side connection channel: the request into the ROB and the release record that comes back.
// I_Req is accepted on any edge where O_Ready is high; with O_Ready low the request is dropped and flagged.
// O_Release is a one-cycle pulse with no back-pressure.
interface port_commit_rob_if;
    import port_commit_rob_pkg::*;

    logic                 I_Req;
    logic [WIDTH_PID-1:0] I_PSrcID;
    logic [WIDTH_PID-1:0] I_PDstID;
    logic [WIDTH_TAG-1:0] I_Tag;
    logic                 O_Ready;
    logic                 O_Release;
    logic [WIDTH_TAG-1:0] O_RelTag;
    logic [WIDTH_PID-1:0] O_RelPSrcID;
    logic [WIDTH_PID-1:0] O_RelPDstID;

    modport master (
        output I_Req, I_PSrcID, I_PDstID, I_Tag,
        input  O_Ready, O_Release, O_RelTag, O_RelPSrcID, O_RelPDstID
    );

    modport slave (
        input  I_Req, I_PSrcID, I_PDstID, I_Tag,
        output O_Ready, O_Release, O_RelTag, O_RelPSrcID, O_RelPDstID
    );
endinterface

// File: rtl/port_commit_rob_oldest_match.sv
// Circular priority select: returns the first set candidate at or after head, wrapping around.
module rob_oldest_match #(
    parameter int DEPTH = 8,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] cand,
    input  logic [W-1:0]     head,
    output logic             found,
    output logic [W-1:0]     idx
);
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (cand[head + k[W-1:0]]) begin
                found = 1'b1;
                idx   = head + k[W-1:0];
            end
        end
    end
endmodule

// File: rtl/port_commit_rob.sv
// In-order reorder buffer for port connections: records requests, collects per-unit commits,
// and retires one entry per cycle in issue order with a one-hot ack and a release record.
module port_commit_rob
    import port_commit_rob_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    port_commit_rob_if.slave           rn,
    input  logic [NUM_UNITS-1:0]       I_Commit,
    output logic [NUM_UNITS-1:0]       O_Ack,
    output logic [WIDTH_ROB_DEPTH:0]   O_Count,
    output logic                       O_Empty,
    output logic                       O_Full,
    output logic                       O_ErrOvf,
    output logic                       O_ErrOrphan
);
    rob_entry_t                 rob_q [ROB_DEPTH];
    logic [WIDTH_ROB_DEPTH-1:0] head_q, tail_q;
    logic [WIDTH_ROB_DEPTH:0]   count_q;

    logic alloc, retire, orphan;
    logic [NUM_UNITS-1:0][ROB_DEPTH-1:0]       cand;
    logic [NUM_UNITS-1:0]                      found;
    logic [NUM_UNITS-1:0][WIDTH_ROB_DEPTH-1:0] match_idx;
    logic [ROB_DEPTH-1:0]                      done_set;

    assign O_Count    = count_q;
    assign O_Empty    = (count_q == '0);
    assign O_Full     = (count_q == (WIDTH_ROB_DEPTH+1)'(ROB_DEPTH));
    assign rn.O_Ready = ~O_Full;

    assign alloc  = rn.I_Req & ~O_Full;
    assign retire = rob_q[head_q].valid & rob_q[head_q].done;

    // The slot being written this cycle is still invalid, so it can never match a commit.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                cand[u][i] = rob_q[i].valid & ~rob_q[i].done &
                             (rob_q[i].pdst_id == u[WIDTH_PID-1:0]);
            end
        end
    end

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_match
        rob_oldest_match #(.DEPTH(ROB_DEPTH), .W(WIDTH_ROB_DEPTH)) u_match (
            .cand  (cand[g]),
            .head  (head_q),
            .found (found[g]),
            .idx   (match_idx[g])
        );
    end

    always_comb begin
        done_set = '0;
        orphan   = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (I_Commit[u]) begin
                if (found[u]) done_set[match_idx[u]] = 1'b1;
                else          orphan                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            O_Ack          <= '0;
            rn.O_Release   <= 1'b0;
            rn.O_RelTag    <= '0;
            rn.O_RelPSrcID <= '0;
            rn.O_RelPDstID <= '0;
            O_ErrOvf       <= 1'b0;
            O_ErrOrphan    <= 1'b0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (done_set[i]) rob_q[i].done <= 1'b1;
            end
            if (retire) begin
                rob_q[head_q].valid <= 1'b0;
                rob_q[head_q].done  <= 1'b0;
                head_q              <= head_q + 1'b1;
                O_Ack               <= pid_onehot(rob_q[head_q].psrc_id);
                rn.O_Release        <= 1'b1;
                rn.O_RelTag         <= rob_q[head_q].tag;
                rn.O_RelPSrcID      <= rob_q[head_q].psrc_id;
                rn.O_RelPDstID      <= rob_q[head_q].pdst_id;
            end else begin
                O_Ack        <= '0;
                rn.O_Release <= 1'b0;
            end
            if (alloc) begin
                rob_q[tail_q] <= '{valid: 1'b1, done: 1'b0, psrc_id: rn.I_PSrcID,
                                   pdst_id: rn.I_PDstID, tag: rn.I_Tag};
                tail_q        <= tail_q + 1'b1;
            end
            case ({alloc, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (rn.I_Req & O_Full) O_ErrOvf    <= 1'b1;
            if (orphan)            O_ErrOrphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_port_commit_rob.sv
// Bench for port_commit_rob: queue-based reference model, expected-release scoreboard and
// a negedge monitor comparing occupancy, flags and every ack/release against the model.
module tb_port_commit_rob;
    import port_commit_rob_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_UNITS-1:0]     I_Commit = '0;
    logic [NUM_UNITS-1:0]     O_Ack;
    logic [WIDTH_ROB_DEPTH:0] O_Count;
    logic                     O_Empty, O_Full, O_ErrOvf, O_ErrOrphan;

    port_commit_rob_if rn_if ();

    port_commit_rob dut (
        .clock       (clock),
        .reset       (reset),
        .rn          (rn_if.slave),
        .I_Commit    (I_Commit),
        .O_Ack       (O_Ack),
        .O_Count     (O_Count),
        .O_Empty     (O_Empty),
        .O_Full      (O_Full),
        .O_ErrOvf    (O_ErrOvf),
        .O_ErrOrphan (O_ErrOrphan)
    );

    always #5 clock = ~clock;

    // Reference model: a plain FIFO of outstanding connections.
    typedef struct {
        logic [3:0] src;
        logic [3:0] dst;
        logic [3:0] tag;
        bit         done;
    } m_ent_t;

    m_ent_t      m_q[$];
    bit          m_ovf, m_orph;
    logic [11:0] exp_q[$];
    int          checks = 0, failures = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        int  sz0;
        bit  ret, hit;
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_ovf  = 1'b0;
            m_orph = 1'b0;
        end else begin
            sz0 = m_q.size();
            ret = (sz0 > 0) && m_q[0].done;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (I_Commit[u]) begin
                    hit = 1'b0;
                    for (int i = 0; i < m_q.size(); i++) begin
                        if (!hit && !m_q[i].done && m_q[i].dst == u) begin
                            m_q[i].done = 1'b1;
                            hit = 1'b1;
                        end
                    end
                    if (!hit) m_orph = 1'b1;
                end
            end
            if (ret) begin
                exp_q.push_back({m_q[0].src, m_q[0].dst, m_q[0].tag});
                void'(m_q.pop_front());
            end
            if (rn_if.I_Req) begin
                if (sz0 < ROB_DEPTH)
                    m_q.push_back('{src: rn_if.I_PSrcID, dst: rn_if.I_PDstID, tag: rn_if.I_Tag, done: 1'b0});
                else
                    m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        logic [11:0] e;
        if (mon_en) begin
            chk("count", int'(O_Count), m_q.size());
            chk("empty", int'(O_Empty), int'(m_q.size() == 0));
            chk("full", int'(O_Full), int'(m_q.size() == ROB_DEPTH));
            chk("ready", int'(rn_if.O_Ready), int'(m_q.size() != ROB_DEPTH));
            chk("err_ovf", int'(O_ErrOvf), int'(m_ovf));
            chk("err_orphan", int'(O_ErrOrphan), int'(m_orph));
            if (rn_if.O_Release || O_Ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_release", int'(O_Ack), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack", int'(O_Ack), 1 << e[11:8]);
                    chk("release", int'(rn_if.O_Release), 1);
                    chk("rel_tag", int'(rn_if.O_RelTag), int'(e[3:0]));
                    chk("rel_src", int'(rn_if.O_RelPSrcID), int'(e[11:8]));
                    chk("rel_dst", int'(rn_if.O_RelPDstID), int'(e[7:4]));
                end
            end else begin
                chk("missing_release", exp_q.size(), 0);
            end
        end
    end

    task automatic step(input logic req, input logic [3:0] s, input logic [3:0] d,
                        input logic [3:0] t, input logic [NUM_UNITS-1:0] c);
        @(negedge clock);
        rn_if.I_Req    = req;
        rn_if.I_PSrcID = s;
        rn_if.I_PDstID = d;
        rn_if.I_Tag    = t;
        I_Commit       = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, '0);
    endtask

    task automatic commit(input int u);
        step(1'b0, 4'd0, 4'd0, 4'd0, NUM_UNITS'(1) << u);
    endtask

    task automatic drain(input int budget);
        int n;
        logic [NUM_UNITS-1:0] c;
        n = 0;
        while (m_q.size() > 0 && n < budget) begin
            c = '0;
            foreach (m_q[i]) if (!m_q[i].done) c[m_q[i].dst] = 1'b1;
            step(1'b0, 4'd0, 4'd0, 4'd0, c);
            n++;
        end
        idle(3);
        chk("drain_done", m_q.size(), 0);
    endtask

    initial begin
        rn_if.I_Req = 1'b0; rn_if.I_PSrcID = '0; rn_if.I_PDstID = '0; rn_if.I_Tag = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(3);

        // single connection: ack lands two cycles after the commit pulse
        step(1'b1, 4'd2, 4'd5, 4'd3, '0);
        idle(2);
        commit(5);
        idle(4);

        // younger commits first; the older one gates both retirements
        step(1'b1, 4'd1, 4'd4, 4'd1, '0);
        step(1'b1, 4'd3, 4'd6, 4'd2, '0);
        commit(6);
        idle(2);
        commit(4);
        idle(4);

        // fill, then overflow while full
        for (int i = 0; i < ROB_DEPTH; i++) step(1'b1, 4'(i), 4'(i + 8), 4'(i), '0);
        step(1'b1, 4'd15, 4'd15, 4'd15, '0);
        idle(2);
        drain(40);

        // two entries to the same destination: one commit per entry, oldest first
        step(1'b1, 4'd10, 4'd7, 4'd10, '0);
        step(1'b1, 4'd11, 4'd7, 4'd11, '0);
        commit(7);
        idle(3);
        commit(7);
        idle(3);

        // orphan commit
        commit(9);
        idle(2);

        // pointer wrap with overlapping allocate and retire
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 4'(i % 16), 4'(i), '0);
            commit(i % 16);
        end
        drain(40);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [NUM_UNITS-1:0] c;
            c = '0;
            if (m_q.size() > 0 && $urandom_range(0, 99) < 55)
                c[m_q[$urandom_range(0, m_q.size() - 1)].dst] = 1'b1;
            if (m_q.size() > 0 && $urandom_range(0, 99) < 25)
                c[m_q[$urandom_range(0, m_q.size() - 1)].dst] = 1'b1;
            if ($urandom_range(0, 99) < 2)
                c[$urandom_range(0, 15)] = 1'b1;
            step($urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), c);
        end

        // mid-operation reset discards pending entries without any ack
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 4'(i), 4'(i), '0);
        commit(0);
        @(negedge clock);
        rn_if.I_Req = 1'b0;
        I_Commit    = '0;
        reset       = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle(4);

        step(1'b1, 4'd6, 4'd2, 4'd9, '0);
        idle(1);
        commit(2);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
